// File: rtl/div_iter_ctrl_pkg.sv
// Shared widths and FSM state type for the iterative divider.
// DIV_QW is always half of DIV_DW.
package div_iter_ctrl_pkg;
  localparam int DIV_DW = 48;
  localparam int DIV_QW = DIV_DW / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/div_iter_ctrl_fa.sv
// Ripple-style full adder: {co,s} = a + b + op.
// The carry-out doubles as the "no borrow" flag when used as a subtractor.
module fa_48b #(
  parameter int W = 48
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, op};
endmodule

// File: rtl/div_iter_ctrl.sv
// Restoring divider: one quotient bit per cycle.
// Only Q[QW:1] of the quotient is published on out.
module div_iter_ctrl
  import div_iter_ctrl_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int QW = DIV_QW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          ready,
  output logic          done,
  output logic [QW-1:0] out,
  output logic          div_zero
);
  localparam int KW = $clog2(DW);

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [KW-1:0] k_q, k_d;
  logic [QW-1:0] out_q, out_d;
  logic          dz_q, dz_d;

  logic [DW-1:0] t;
  logic [DW-1:0] diff;
  logic          c;
  logic          unused_msb;

  // Old R MSB falls off the shift; Q MSB never reaches out.
  assign t          = {r_q[DW-2:0], a_q[k_q]};
  assign unused_msb = ^{r_q[DW-1], q_q[DW-1]};

  fa_48b #(.W(DW)) u_fa (
    .a  (t),
    .b  (~b_q),
    .op (1'b1),
    .s  (diff),
    .co (c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    k_d     = k_q;
    out_d   = out_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          r_d     = '0;
          q_d     = '0;
          k_d     = KW'(DW - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_d = c ? diff : t;
        q_d = {q_q[DW-2:0], c};
        if (k_q == '0) begin
          state_d = S_DONE;
          out_d   = q_d[QW:1];
          dz_d    = (b_q == '0);
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      k_q     <= '0;
      out_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      k_q     <= k_d;
      out_q   <= out_d;
      dz_q    <= dz_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign out      = out_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_div_iter_ctrl.sv
// Bench for div_iter_ctrl: latency/result scoreboard plus directed cases.
// Model computes the quotient bit-serially with plain integer compares.
module tb_div_iter_ctrl;
  localparam int DW = 48;
  localparam int QW = 24;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          ready;
  logic          done;
  logic [QW-1:0] out;
  logic          div_zero;

  int checks;
  int errors;

  div_iter_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .out      (out),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] gold(input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    logic [DW-1:0] r;
    logic [DW-1:0] q;
    logic [DW-1:0] t;
    r = '0;
    q = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      t = (r << 1) | DW'(x[i]);
      if (t >= y) begin
        r    = t - y;
        q[i] = 1'b1;
      end else begin
        r = t;
      end
    end
    return q;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: cycles left until idle, plus results expected on out.
  int            m_cnt;
  logic [QW-1:0] m_out, m_pend;
  logic          m_dz, m_pdz;
  logic [DW-1:0] qtmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_out = '0;
      m_dz  = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        qtmp   = gold(a, b);
        m_pend = qtmp[QW:1];
        m_pdz  = (b == '0);
        m_cnt  = DW + 1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_out = m_pend;
        m_dz  = m_pdz;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", 64'(ready), 64'(m_cnt == 0));
      check("done", 64'(done), 64'(m_cnt == 1));
      check("out", 64'(out), 64'(m_out));
      check("div_zero", 64'(div_zero), 64'(m_dz));
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (ready) return;
      @(posedge clk);
      #1;
    end
    check("ready_timeout", 64'(0), 64'(1));
  endtask

  // Returns edges counted after the accepting edge until done shows.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        return;
      end
    end
    check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_op(input logic [DW-1:0] x, input logic [DW-1:0] y,
                        output int lat);
    wait_ready();
    start = 1'b1;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    wait_done(lat);
  endtask

  int            lat;
  logic [DW-1:0] qg;
  logic [DW-1:0] ra, rb;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;

    qg = gold(48'd100, 48'd7);
    check("gold_100_7", 64'(qg), 64'd14);
    qg = gold(48'd5, 48'd0);
    check("gold_div0", 64'(qg), 64'hFFFF_FFFF_FFFF);
    qg = gold(48'h800000000000, 48'h000000800000);
    check("gold_pow2", 64'(qg), 64'h1000000);

    #12;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(48'd100, 48'd7, lat);
    check("lat_100_7", 64'(lat), 64'd48);
    check("out_100_7", 64'(out), 64'd7);
    check("dz_100_7", 64'(div_zero), 64'd0);

    run_op(48'h800000000000, 48'h000000800000, lat);
    check("out_pow2", 64'(out), 64'h800000);

    run_op(48'd5, 48'd0, lat);
    check("out_div0", 64'(out), 64'hFFFFFF);
    check("dz_div0", 64'(div_zero), 64'd1);
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_out", 64'(out), 64'hFFFFFF);
    check("hold_dz", 64'(div_zero), 64'd1);

    // Back-to-back with start held; a changes mid-run.
    wait_ready();
    start = 1'b1;
    a     = 48'd100;
    b     = 48'd7;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    a = 48'hFFFF_FFFF_FFFF;
    wait_done(lat);
    check("b2b_op1_out", 64'(out), 64'd7);
    wait_done(lat);
    check("b2b_gap", 64'(lat), 64'd50);
    qg = gold(48'hFFFF_FFFF_FFFF, 48'd7);
    check("b2b_op2_out", 64'(out), 64'(qg[QW:1]));
    start = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of RUN.
    run_op(48'd1000, 48'd3, lat);
    wait_ready();
    start = 1'b1;
    a     = 48'd12345;
    b     = 48'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;

    // Random pairs, biased toward MSB-set and oversized divisors.
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      unique case (i % 4)
        0: rb = rb | 48'h800000000000;
        1: rb = rb >> $urandom_range(47, 1);
        2: ra = ra >> $urandom_range(47, 0);
        default: ;
      endcase
      run_op(ra, rb, lat);
      qg = gold(ra, rb);
      check("rand_lat", 64'(lat), 64'd48);
      check("rand_out", 64'(out), 64'(qg[QW:1]));
    end

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
